// File: rtl/nexus_pkg.sv
// Shared widths and helpers for the Nexus nonce collector.
package nexus_pkg;

  localparam int NONCE_W     = 64;
  localparam int DROP_CNT_W  = 16;
  localparam int FOUND_CNT_W = 32;

  typedef logic [NONCE_W-1:0] nonce_t;

  // Saturating add for the drop counter; several cores may drop in one cycle.
  function automatic logic [DROP_CNT_W-1:0] sat_add_drop(
    input logic [DROP_CNT_W-1:0] cnt,
    input int unsigned           inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, cnt} + (DROP_CNT_W+1)'(inc);
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/nexus_nonce_fifo.sv
// Synchronous circular-buffer FIFO; extra pointer MSB separates full from empty.
module nexus_nonce_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign level_o = wr_q - rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer update; flush empties the buffer without touching storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/nexus_nonce_collector.sv
// Gathers per-core nonce hits, arbitrates them round-robin into a FIFO and
// emits rate-limited GoodNonceFound strobes toward the miner register block.
module nexus_nonce_collector
  import nexus_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int DEPTH  = 8,
  parameter int GAP    = 4
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic                       nHashRst,
  input  logic [NCORES-1:0]          i_found,
  input  logic [NONCE_W*NCORES-1:0]  i_nonce,
  output logic                       o_good_nonce_found,
  output logic [NONCE_W-1:0]         o_nonce_out,
  output logic [$clog2(DEPTH):0]     o_fifo_level,
  output logic [DROP_CNT_W-1:0]      o_drop_count,
  output logic [FOUND_CNT_W-1:0]     o_found_count
);
  localparam int         IW    = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [7:0] GAP_L = 8'(GAP);

  logic [NCORES-1:0][NONCE_W-1:0] pend_q, pend_d;
  logic [NCORES-1:0]              pend_v_q, pend_v_d;
  logic [NCORES-1:0]              gnt_oh, drop;
  logic [IW-1:0]                  rr_ptr_q, rr_ptr_d, gnt_idx;
  logic                           gnt_v, flush, pop;
  logic                           fifo_full, fifo_empty;
  nonce_t                         fifo_head;
  logic [7:0]                     gap_q;

  assign flush = !nHashRst;
  assign pop   = !fifo_empty && (gap_q == 8'd0) && !flush;

  // Round-robin pick starting at rr_ptr; nothing is granted into a full FIFO.
  always_comb begin
    int c;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    c       = 0;
    for (int i = 0; i < NCORES; i++) begin
      c = (int'(rr_ptr_q) + i) % NCORES;
      if (!gnt_v && pend_v_q[IW'(c)] && !fifo_full && !flush) begin
        gnt_v   = 1'b1;
        gnt_idx = IW'(c);
      end
    end
  end

  // Pointer moves past the core just served.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_v) rr_ptr_d = (int'(gnt_idx) == NCORES-1) ? '0 : gnt_idx + IW'(1);
  end

  // Per-core one-deep capture; a granted slot can be refilled in the same cycle.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    gnt_oh   = '0;
    drop     = '0;
    for (int k = 0; k < NCORES; k++) begin
      gnt_oh[k] = gnt_v && (gnt_idx == IW'(k));
      if (flush) begin
        pend_v_d[k] = 1'b0;
      end else if (i_found[k] && (!pend_v_q[k] || gnt_oh[k])) begin
        pend_d[k]   = i_nonce[k*NONCE_W +: NONCE_W];
        pend_v_d[k] = 1'b1;
      end else begin
        if (gnt_oh[k]) pend_v_d[k] = 1'b0;
        drop[k] = i_found[k] && pend_v_q[k];
      end
    end
  end

  // Pending registers and arbiter pointer.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pend_q   <= '0;
      pend_v_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  nexus_nonce_fifo #(.DEPTH(DEPTH), .WIDTH(NONCE_W)) u_fifo (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .flush_i (flush),
    .push_i  (gnt_v),
    .din_i   (pend_q[gnt_idx]),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .level_o (o_fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output strobe, held nonce, counters and inter-strobe gap timer.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      o_good_nonce_found <= 1'b0;
      o_nonce_out        <= '0;
      o_found_count      <= '0;
      o_drop_count       <= '0;
      gap_q              <= '0;
    end else if (flush) begin
      o_good_nonce_found <= 1'b0;
      gap_q              <= '0;
    end else begin
      o_good_nonce_found <= pop;
      o_drop_count       <= sat_add_drop(o_drop_count, $countones(drop));
      if (pop) begin
        o_nonce_out   <= fifo_head;
        o_found_count <= o_found_count + FOUND_CNT_W'(1);
        gap_q         <= GAP_L;
      end else if (gap_q != 8'd0) begin
        gap_q <= gap_q - 8'd1;
      end
    end
  end

endmodule
